// File: rtl/conv_readout.sv
// Streams a snapshot of the 3-channel WxW conv result one spatial position per beat,
// optionally 2x2 max-pooled, under a valid/ready handshake.
module conv_readout #(
  parameter int DW   = 8,
  parameter int W    = 6,
  parameter int CH   = 3,
  parameter int POOL = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [W*W*CH*DW-1:0]   conv_lin,
  input  logic                   out_rdy,
  output logic                   out_vld,
  output logic [DW-1:0]          out_D1,
  output logic [DW-1:0]          out_D2,
  output logic [DW-1:0]          out_D3,
  output logic [5:0]             out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int HW = W / 2;
  localparam int N  = (POOL != 0) ? HW * HW : W * W;
  localparam int VW = W * W * CH * DW;
  localparam logic [5:0] LAST_IDX = 6'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [VW-1:0]   snap_r;
  logic [5:0]      idx_r;
  logic [VW-1:0]   src_s;
  logic [5:0]      nidx_s;
  logic [DW-1:0]   data_s [3];

  function automatic logic [DW-1:0] elem(input logic [VW-1:0] v, input int ch,
                                         input int r, input int c);
    return v[(ch * W * W + r * W + c) * DW +: DW];
  endfunction

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Data for one channel at beat index idx; out-of-range indices clamp to the last beat.
  function automatic logic [DW-1:0] beat(input logic [VW-1:0] v, input int ch,
                                         input logic [5:0] idx);
    int i;
    int pr;
    int pc;
    i = (int'(idx) < N) ? int'(idx) : N - 1;
    if (POOL == 0) begin
      return elem(v, ch, i / W, i % W);
    end else begin
      pr = i / HW;
      pc = i % HW;
      return max2(max2(elem(v, ch, 2 * pr, 2 * pc),     elem(v, ch, 2 * pr, 2 * pc + 1)),
                  max2(elem(v, ch, 2 * pr + 1, 2 * pc), elem(v, ch, 2 * pr + 1, 2 * pc + 1)));
    end
  endfunction

  // Next-beat data: first beat reads conv_lin directly as it is being captured.
  always_comb begin
    src_s  = conv_lin;
    nidx_s = 6'd0;
    if (state_r == SEND) begin
      src_s  = snap_r;
      nidx_s = idx_r + 6'd1;
    end else begin
      src_s  = conv_lin;
      nidx_s = 6'd0;
    end
    for (int k = 0; k < 3; k++) begin
      data_s[k] = beat(src_s, k, nidx_s);
    end
  end

  // Readout FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      snap_r   <= '0;
      idx_r    <= 6'd0;
      out_vld  <= 1'b0;
      out_D1   <= '0;
      out_D2   <= '0;
      out_D3   <= '0;
      out_idx  <= 6'd0;
      out_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          out_vld  <= 1'b0;
          out_last <= 1'b0;
          if (start) begin
            snap_r   <= conv_lin;
            idx_r    <= 6'd0;
            out_idx  <= 6'd0;
            out_D1   <= data_s[0];
            out_D2   <= data_s[1];
            out_D3   <= data_s[2];
            out_vld  <= 1'b1;
            out_last <= (LAST_IDX == 6'd0);
            busy     <= 1'b1;
            state_r  <= SEND;
          end
        end
        SEND: begin
          if (out_rdy) begin
            if (idx_r == LAST_IDX) begin
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              done     <= 1'b1;
              state_r  <= DONE;
            end else begin
              idx_r    <= nidx_s;
              out_idx  <= nidx_s;
              out_D1   <= data_s[0];
              out_D2   <= data_s[1];
              out_D3   <= data_s[2];
              out_last <= (nidx_s == LAST_IDX);
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_readout.sv
// Scoreboard bench for conv_readout: one raw instance (POOL=0) and one pooled instance (POOL=1).
module tb_conv_readout;

  localparam int VW = 6 * 6 * 3 * 8;

  typedef struct {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic [5:0] idx;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic rdy0 = 1'b0, rdy1 = 1'b0;
  logic [VW-1:0] conv0 = '0, conv1 = '0;
  logic vld0, last0, busy0, done0, vld1, last1, busy1, done1;
  logic [7:0] a1, a2, a3, b1, b2, b3;
  logic [5:0] idx0, idx1;

  beat_t sb0[$];
  beat_t sb1[$];
  int checks = 0;
  int errors = 0;
  int beats0 = 0;
  int beats1 = 0;
  int m1[3][6][6];

  conv_readout #(.DW(8), .W(6), .CH(3), .POOL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .conv_lin(conv0), .out_rdy(rdy0),
    .out_vld(vld0), .out_D1(a1), .out_D2(a2), .out_D3(a3), .out_idx(idx0),
    .out_last(last0), .busy(busy0), .done(done0));

  conv_readout #(.DW(8), .W(6), .CH(3), .POOL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .conv_lin(conv1), .out_rdy(rdy1),
    .out_vld(vld1), .out_D1(b1), .out_D2(b2), .out_D3(b3), .out_idx(idx1),
    .out_last(last1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  // Raw-instance scoreboard and hold-while-stalled monitor.
  logic pv0 = 1'b0, pr0 = 1'b0;
  logic [30:0] pd0 = '0;
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && vld0 && rdy0) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL beat0_extra actual idx=%0d required no beat", idx0);
      end else begin
        e = sb0.pop_front();
        if ({a1, a2, a3, idx0, last0} !== {e.d1, e.d2, e.d3, e.idx, e.last}) begin
          errors++;
          $display("FAIL beat0 actual d=%0d,%0d,%0d idx=%0d last=%0b required d=%0d,%0d,%0d idx=%0d last=%0b",
                   a1, a2, a3, idx0, last0, e.d1, e.d2, e.d3, e.idx, e.last);
        end
        beats0++;
      end
    end
    if (rst_n && pv0 && !pr0) begin
      checks++;
      if (!vld0 || {a1, a2, a3, idx0, last0} !== pd0) begin
        errors++;
        $display("FAIL hold0 actual vld=%0b data=%0h required vld=1 data=%0h",
                 vld0, {a1, a2, a3, idx0, last0}, pd0);
      end
    end
    pv0 = vld0;
    pr0 = rdy0;
    pd0 = {a1, a2, a3, idx0, last0};
  end

  // Pooled-instance scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && vld1 && rdy1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL beat1_extra actual idx=%0d required no beat", idx1);
      end else begin
        e = sb1.pop_front();
        if ({b1, b2, b3, idx1, last1} !== {e.d1, e.d2, e.d3, e.idx, e.last}) begin
          errors++;
          $display("FAIL beat1 actual d=%0d,%0d,%0d idx=%0d last=%0b required d=%0d,%0d,%0d idx=%0d last=%0b",
                   b1, b2, b3, idx1, last1, e.d1, e.d2, e.d3, e.idx, e.last);
        end
        beats1++;
      end
    end
  end

  task automatic load_pattern0();
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          conv0[(ch * 36 + r * 6 + c) * 8 +: 8] = 8'(ch * 64 + r * 6 + c);
  endtask

  task automatic push_pattern0();
    beat_t e;
    for (int i = 0; i < 36; i++) begin
      e.d1 = 8'(i); e.d2 = 8'(64 + i); e.d3 = 8'(128 + i);
      e.idx = 6'(i); e.last = (i == 35);
      sb0.push_back(e);
    end
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  // Waits until the chosen scoreboard drains; ok=0 if the budget expires.
  task automatic wait_drain(input int which, input bit rnd, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (rnd) rdy0 = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if ((which == 0 && sb0.size() == 0) || (which == 1 && sb1.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    rdy0 = 1'b1;
  endtask

  task automatic wait_beats0(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (beats0 >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({vld0, a1, a2, a3, idx0, last0, busy0, done0} !== 36'd0) begin
      errors++;
      $display("FAIL reset0 actual=%0h required=0", {vld0, a1, a2, a3, idx0, last0, busy0, done0});
    end
    checks++;
    if ({vld1, b1, b2, b3, idx1, last1, busy1, done1} !== 36'd0) begin
      errors++;
      $display("FAIL reset1 actual=%0h required=0", {vld1, b1, b2, b3, idx1, last1, busy1, done1});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
  endtask

  task automatic check_done0(input string tag);
    @(negedge clk);
    checks++;
    if ({done0, busy0, vld0, last0} !== 4'b1100) begin
      errors++;
      $display("FAIL %s_done actual done,busy,vld,last=%b required 1100", tag, {done0, busy0, vld0, last0});
    end
    @(negedge clk);
    checks++;
    if ({done0, busy0, vld0} !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle actual done,busy,vld=%b required 000", tag, {done0, busy0, vld0});
    end
  endtask

  task automatic test_stream();
    bit ok;
    load_pattern0();
    beats0 = 0;
    push_pattern0();
    @(posedge clk); #1 start0 = 1'b1;
    @(negedge clk);
    checks++;
    if (vld0 !== 1'b0) begin
      errors++;
      $display("FAIL latency_early actual vld=%0b required 0", vld0);
    end
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({vld0, busy0, idx0} !== {1'b1, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL latency actual vld=%0b busy=%0b idx=%0d required vld=1 busy=1 idx=0", vld0, busy0, idx0);
    end
    wait_drain(0, 1'b0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stream_timeout actual left=%0d required 0", sb0.size()); end
    check_done0("stream");
  endtask

  task automatic test_backpressure();
    bit ok;
    load_pattern0();
    push_pattern0();
    pulse_start0();
    wait_drain(0, 1'b1, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout actual left=%0d required 0", sb0.size()); end
    check_done0("bp");
  endtask

  task automatic test_snapshot();
    bit ok;
    load_pattern0();
    push_pattern0();
    pulse_start0();
    conv0 = {VW{1'b1}};
    wait_drain(0, 1'b0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL snap_timeout actual left=%0d required 0", sb0.size()); end
    check_done0("snap");
  endtask

  task automatic test_pool();
    bit ok;
    beat_t e;
    int mx[3];
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          m1[ch][r][c] = (ch * 37 + r * 11 + c * 5) % 256;
    m1[0][0][0] = 3; m1[0][0][1] = 200; m1[0][1][0] = 17; m1[0][1][1] = 199;
    m1[1][0][0] = 5; m1[1][0][1] = 5;   m1[1][1][0] = 5;  m1[1][1][1] = 5;
    m1[2][0][0] = 0; m1[2][0][1] = 0;   m1[2][1][0] = 0;  m1[2][1][1] = 1;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          conv1[(ch * 36 + r * 6 + c) * 8 +: 8] = 8'(m1[ch][r][c]);
    for (int p = 0; p < 9; p++) begin
      for (int ch = 0; ch < 3; ch++) begin
        mx[ch] = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (m1[ch][2 * (p / 3) + dr][2 * (p % 3) + dc] > mx[ch])
              mx[ch] = m1[ch][2 * (p / 3) + dr][2 * (p % 3) + dc];
      end
      e.d1 = 8'(mx[0]); e.d2 = 8'(mx[1]); e.d3 = 8'(mx[2]);
      e.idx = 6'(p); e.last = (p == 8);
      sb1.push_back(e);
    end
    beats1 = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({b1, b2, b3} !== {8'd200, 8'd5, 8'd1}) begin
      errors++;
      $display("FAIL pool_beat0 actual %0d,%0d,%0d required 200,5,1", b1, b2, b3);
    end
    wait_drain(1, 1'b0, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pool_timeout actual left=%0d required 0", sb1.size()); end
    @(negedge clk);
    checks++;
    if ({done1, vld1} !== 2'b10) begin
      errors++;
      $display("FAIL pool_done actual done,vld=%b required 10", {done1, vld1});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (beats1 !== 9) begin errors++; $display("FAIL pool_count actual=%0d required=9", beats1); end
  endtask

  task automatic test_extra_start();
    bit ok;
    load_pattern0();
    beats0 = 0;
    push_pattern0();
    pulse_start0();
    wait_beats0(10, 100, ok);
    pulse_start0();
    wait_drain(0, 1'b0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL extra_timeout actual left=%0d required 0", sb0.size()); end
    check_done0("extra");
    repeat (3) @(negedge clk);
    checks++;
    if ({beats0, vld0, busy0} !== {32'd36, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL extra_ignored actual beats=%0d vld=%0b busy=%0b required beats=36 vld=0 busy=0",
               beats0, vld0, busy0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_pattern0();
    beats0 = 0;
    push_pattern0();
    pulse_start0();
    wait_beats0(20, 100, ok);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({vld0, a1, a2, a3, idx0, last0, busy0, done0} !== 36'd0) begin
      errors++;
      $display("FAIL midreset actual=%0h required=0", {vld0, a1, a2, a3, idx0, last0, busy0, done0});
    end
    sb0.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if ({done0, vld0, busy0} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_quiet actual done,vld,busy=%b required 000", {done0, vld0, busy0});
      end
    end
    beats0 = 0;
    push_pattern0();
    pulse_start0();
    wait_drain(0, 1'b0, 100, ok);
    checks++;
    if (!ok || beats0 !== 36) begin
      errors++;
      $display("FAIL restart actual beats=%0d required 36", beats0);
    end
    check_done0("restart");
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_pattern0();
    beats0 = 0;
    push_pattern0();
    push_pattern0();
    @(posedge clk); #1 start0 = 1'b1;
    wait_beats0(36, 100, ok);
    @(negedge clk);
    checks++;
    if ({done0, vld0} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_done actual done,vld=%b required 10", {done0, vld0});
    end
    @(negedge clk);
    checks++;
    if ({done0, vld0, busy0} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_gap actual done,vld,busy=%b required 000", {done0, vld0, busy0});
    end
    @(negedge clk);
    checks++;
    if ({vld0, idx0} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL b2b_restart actual vld=%0b idx=%0d required vld=1 idx=0", vld0, idx0);
    end
    wait_drain(0, 1'b0, 100, ok);
    start0 = 1'b0;
    checks++;
    if (!ok || beats0 !== 72) begin
      errors++;
      $display("FAIL b2b_count actual beats=%0d required 72", beats0);
    end
    check_done0("b2b");
    repeat (3) @(negedge clk);
    checks++;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL b2b_stop actual vld=%0b required 0", vld0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_snapshot();
    test_pool();
    test_extra_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
